// File: rtl/conv_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_scheduler_if
//  Description : Scheduler <-> datapath/memory signal bundle for conv_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
interface conv_scheduler_if #(
    parameter int AW = 3,
    parameter int FW = 2,
    parameter int P  = 3
);
    logic          x_full;
    logic          out_ready;
    logic [AW-1:0] x_base;
    logic [FW-1:0] f_addr;
    logic          clr_acc;
    logic [P-1:0]  en_acc;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [P-1:0]  wr_count;
    logic          x_release;
    logic          busy;

    modport master (
        input  x_full, out_ready,
        output x_base, f_addr, clr_acc, en_acc, wr_en, wr_addr, wr_count,
               x_release, busy
    );

    modport slave (
        output x_full, out_ready,
        input  x_base, f_addr, clr_acc, en_acc, wr_en, wr_addr, wr_count,
               x_release, busy
    );
endinterface
`default_nettype wire

// File: rtl/conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : conv_scheduler
//  Description : Sequences a P-lane 1-D convolution (valid outputs only) over
//                LENX inputs and a LENF-tap filter. Define CONV_SCHED_STALL_EN
//                to add a stall input that freezes the CLR/MAC/DRAIN phases.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_scheduler #(
    parameter int LENX = 8,
    parameter int LENF = 4,
    parameter int P    = 3,
    parameter int AW   = 3,
    parameter int FW   = 2
) (
    input  logic clk,
    input  logic reset,
`ifdef CONV_SCHED_STALL_EN
    input  logic stall,
`endif
    conv_scheduler_if.master bus
);
    localparam int NOUT   = LENX - LENF + 1;
    localparam int NGRP   = (NOUT + P - 1) / P;
    // gb can overshoot the last valid output by up to P-1 before DONE
    localparam int c_gb_w = AW + $clog2(P + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_gb_w-1:0]   r_gb, w_gb_nxt;
    logic [c_gb_w-1:0]   r_grp, w_grp_nxt;
    logic [FW-1:0]       r_tap, w_tap_nxt;
    logic [AW-1:0]       r_x_base, w_x_base_nxt;
    logic [FW-1:0]       r_f_addr, w_f_addr_nxt;
    logic                r_clr_acc, w_clr_acc_nxt;
    logic [P-1:0]        r_en_acc, w_en_acc_nxt;
    logic [AW-1:0]       r_wr_addr, w_wr_addr_nxt;
    logic [P-1:0]        r_wr_count, w_wr_count_nxt;
    logic                r_x_release, w_x_release_nxt;
    logic                r_busy, w_busy_nxt;
    logic [P-1:0]        w_lane_mask;
    logic [P-1:0]        w_count;
    logic                w_wr_fire;
    logic                w_stall;
    int                  w_remain;

`ifdef CONV_SCHED_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Write strobe must answer out_ready in the same cycle, so it is not registered
    assign w_wr_fire = (r_state == S_WRITE) && bus.out_ready && !reset;

    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < P; i++) begin
            w_lane_mask[i] = (int'(r_gb) + i) < NOUT;
        end
        w_remain = NOUT - int'(r_gb);
        w_count  = (w_remain > P) ? P'(P) : P'(w_remain);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gb        <= '0;
            r_grp       <= '0;
            r_tap       <= '0;
            r_x_base    <= '0;
            r_f_addr    <= '0;
            r_clr_acc   <= 1'b1;
            r_en_acc    <= '0;
            r_wr_addr   <= '0;
            r_wr_count  <= '0;
            r_x_release <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gb        <= w_gb_nxt;
            r_grp       <= w_grp_nxt;
            r_tap       <= w_tap_nxt;
            r_x_base    <= w_x_base_nxt;
            r_f_addr    <= w_f_addr_nxt;
            r_clr_acc   <= w_clr_acc_nxt;
            r_en_acc    <= w_en_acc_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_count  <= w_wr_count_nxt;
            r_x_release <= w_x_release_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        w_state_nxt     = r_state;
        w_gb_nxt        = r_gb;
        w_grp_nxt       = r_grp;
        w_tap_nxt       = r_tap;
        w_x_base_nxt    = r_x_base;
        w_f_addr_nxt    = r_f_addr;
        w_wr_addr_nxt   = r_wr_addr;
        w_clr_acc_nxt   = 1'b0;
        w_en_acc_nxt    = '0;
        w_wr_count_nxt  = '0;
        w_x_release_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.x_full) begin
                    w_state_nxt = S_CLR;
                    w_gb_nxt    = '0;
                    w_grp_nxt   = '0;
                end
            end
            S_CLR: begin
                if (!w_stall) begin
                    w_state_nxt = S_MAC;
                    w_tap_nxt   = '0;
                end
            end
            S_MAC: begin
                if (!w_stall) begin
                    // ROM/memory data for this tap arrives next cycle
                    w_en_acc_nxt = w_lane_mask;
                    if (r_tap == FW'(LENF - 1)) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_tap_nxt = r_tap + FW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!w_stall) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_wr_fire) begin
                    w_gb_nxt    = r_gb + c_gb_w'(P);
                    w_grp_nxt   = r_grp + c_gb_w'(1);
                    w_state_nxt = (r_grp == c_gb_w'(NGRP - 1)) ? S_DONE : S_CLR;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_CLR: begin
                w_clr_acc_nxt = 1'b1;
                w_f_addr_nxt  = '0;
                w_x_base_nxt  = AW'(w_gb_nxt);
            end
            S_MAC: begin
                w_f_addr_nxt = w_tap_nxt;
                w_x_base_nxt = AW'(w_gb_nxt + c_gb_w'(w_tap_nxt));
            end
            S_WRITE: begin
                w_wr_addr_nxt  = AW'(r_gb);
                w_wr_count_nxt = w_count;
            end
            S_DONE: begin
                w_x_release_nxt = 1'b1;
            end
            default: begin
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.x_base    = r_x_base;
    assign bus.f_addr    = r_f_addr;
    assign bus.clr_acc   = r_clr_acc;
    assign bus.en_acc    = r_en_acc;
    assign bus.wr_en     = w_wr_fire;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_count  = r_wr_count;
    assign bus.x_release = r_x_release;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 SHALL provide parameter LENX, default 8: input vector length.
REQ-002 SHALL provide parameter LENF, default 4: filter length.
REQ-003 SHALL provide parameter P, default 3: number of parallel MAC lanes.
REQ-004 SHALL provide parameter AW, default 3: x-address width; FW, default 2: f-address width.
REQ-005 SHALL define NOUT = LENX-LENF+1 and NGRP = ceil(NOUT/P) as derived constants.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- x_full  in  1  input buffer holds LENX samples
- out_ready  in  1  output memory can accept one lane group
- x_base  out  AW  lane-0 x read address; lane i reads x_base+i
- f_addr  out  FW  filter ROM address
- clr_acc  out  1  clears all lane accumulators
- en_acc  out  P  per-lane accumulate enable
- wr_en  out  1  write the lane group to output memory
- wr_addr  out  AW  output base address of the group
- wr_count  out  P bits, one-hot-free count  number of valid lanes in the group (1..P)
- x_release  out  1  one-cycle pulse freeing the input buffer
- busy  out  1  high in every state except IDLE

Function
REQ-007 SHALL implement FSM states IDLE, CLR, MAC, DRAIN, WRITE, DONE.
REQ-008 IDLE: x_full=1 at an edge -> CLR; group base gb := 0.
REQ-009 CLR (1 cycle): clr_acc=1, f_addr=0, x_base=gb -> MAC.
REQ-010 MAC (LENF cycles, tap k=0..LENF-1): f_addr=k, x_base=gb+k; after tap LENF-1 -> DRAIN.
REQ-011 en_acc SHALL be registered, asserted the cycle after each tap address (1-cycle memory/ROM read latency), i.e. MAC cycles 2..LENF and DRAIN.
REQ-012 en_acc[i] SHALL be forced 0 for lanes with gb+i >= NOUT.
REQ-013 DRAIN (1 cycle) -> WRITE.
REQ-014 WRITE: hold until out_ready=1; in that cycle wr_en=1, wr_addr=gb, wr_count=min(P, NOUT-gb); then gb += P; gb >= NOUT -> DONE, else -> CLR.
REQ-015 WRITE with out_ready=0: wr_en=0, en_acc=0, all addresses held.
REQ-016 DONE (1 cycle): x_release=1 -> IDLE.
REQ-017 x_full changes outside IDLE SHALL be ignored.
REQ-018 Outputs not driven by the current state SHALL be 0 (addresses hold last value).

Reset
REQ-019 reset SHALL win over all events, state := IDLE on the next edge, including mid-MAC or mid-WRITE.
REQ-020 Reset values: x_base=0, f_addr=0, clr_acc=1, en_acc=0, wr_en=0, wr_addr=0, wr_count=0, x_release=0, busy=0, gb=0.
REQ-021 clr_acc SHALL drop to 0 in the first IDLE cycle after reset.

Configuration
REQ-022 Macro CONV_SCHED_STALL_EN SHALL add input port stall (1 bit).
REQ-023 With the macro, stall=1 in CLR/MAC/DRAIN SHALL freeze state, tap counter and addresses, and force en_acc=0 that cycle.
REQ-024 Without the macro, the port SHALL be absent and timing SHALL match REQ-009..REQ-016 exactly.

Verification
REQ-025 Defaults, out_ready=1, x_full rises at cycle 0 -> CLR c1, MAC c2-c5, wr_en c7 (wr_addr=0, wr_count=3), wr_en c14 (wr_addr=3, wr_count=2), x_release c15.
REQ-026 Group 2 -> en_acc=3'b011 in every accumulate cycle; group 1 -> 3'b111.
REQ-027 out_ready=0 for 5 cycles in the first WRITE -> wr_en delayed 5 cycles, x_release at c20, no en_acc pulses during the wait.
REQ-028 reset asserted during MAC tap 2 -> next cycle busy=0, clr_acc=1, en_acc=0; x_full=1 restarts cleanly from gb=0.
REQ-029 With CONV_SCHED_STALL_EN, stall=1 for 2 cycles at tap 1 -> f_addr holds 1 for 3 cycles, exactly 4 en_acc pulses per group, x_release at c17.
REQ-030 LENX=8, LENF=4, P=5 -> single group, wr_count=5, en_acc=5'b11111, x_release 8 cycles after x_full.
